// File: rtl/mem_arbiter_2port_if.sv
// Bundles the two requester handshakes and the shared memory handshake.
// slave: arbiter view; master: requesters plus memory model.
interface mem_arbiter_2port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              done0;
    logic              err0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done1;
    logic              err1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_valid;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, wr0, addr0, wdata0,
        output done0, err0, rdata0,
        input  req1, wr1, addr1, wdata1,
        output done1, err1, rdata1,
        output mem_valid, mem_wr, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output req0, wr0, addr0, wdata0,
        input  done0, err0, rdata0,
        output req1, wr1, addr1, wdata1,
        input  done1, err1, rdata1,
        input  mem_valid, mem_wr, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter_2port.sv
// Round-robin two-port arbiter/sequencer for one shared memory handshake with watchdog.
// Define MEM_ARB_STATS_EN to add the cnt0/cnt1/tmo_cnt statistics outputs.
module mem_arbiter_2port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_arbiter_2port_if.slave bus,
    output logic               busy,
    output logic               owner
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]        cnt0,
    output logic [15:0]        cnt1,
    output logic [7:0]         tmo_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              mem_valid_reg, mem_valid_next;
    logic              mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [7:0]        tmo_ctr_reg, tmo_ctr_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [1:0]        rd_load;

    logic [1:0]        req_vec;
    logic [1:0]        wr_vec;
    logic [ADDR_W-1:0] addr_arr [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic              win;

    assign req_vec      = {bus.req1, bus.req0};
    assign wr_vec       = {bus.wr1, bus.wr0};
    assign addr_arr[0]  = bus.addr0;
    assign addr_arr[1]  = bus.addr1;
    assign wdata_arr[0] = bus.wdata0;
    assign wdata_arr[1] = bus.wdata1;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        mem_valid_next = mem_valid_reg;
        mem_wr_next    = mem_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        tmo_ctr_next   = tmo_ctr_reg;
        done_next      = 2'b00;
        err_next       = 2'b00;
        rd_load        = 2'b00;
        win            = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // On a tie the port that was not served last wins.
                win = (req_vec == 2'b11) ? ~owner_reg : req_vec[1];
                if (|req_vec) begin
                    owner_next     = win;
                    mem_valid_next = 1'b1;
                    mem_wr_next    = wr_vec[win];
                    mem_addr_next  = addr_arr[win];
                    mem_wdata_next = wdata_arr[win];
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                // mem_ready here still reflects the previous access, so it is not looked at.
                tmo_ctr_next = 8'd0;
                state_next   = WAIT;
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    mem_valid_next       = 1'b0;
                    done_next[owner_reg] = 1'b1;
                    rd_load[owner_reg]   = ~mem_wr_reg;
                    state_next           = RESP;
                end else if (tmo_ctr_reg == TMO_LAST) begin
                    mem_valid_next       = 1'b0;
                    done_next[owner_reg] = 1'b1;
                    err_next[owner_reg]  = 1'b1;
                    state_next           = RESP;
                end else begin
                    tmo_ctr_next = tmo_ctr_reg + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b1;
            mem_valid_reg <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            tmo_ctr_reg   <= 8'd0;
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            mem_valid_reg <= mem_valid_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            tmo_ctr_reg   <= tmo_ctr_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (rd_load[gi]) begin
                    rdata_reg <= bus.mem_rdata;
                end
            end

`ifdef MEM_ARB_STATS_EN
            logic [15:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 16'd0;
                end else if (done_next[gi] && !err_next[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
`endif
        end
    endgenerate

`ifdef MEM_ARB_STATS_EN
    logic [7:0] tmo_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= 8'd0;
        end else if ((|err_next) && tmo_cnt_reg != 8'hFF) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end

    assign cnt0    = g_port[0].cnt_reg;
    assign cnt1    = g_port[1].cnt_reg;
    assign tmo_cnt = tmo_cnt_reg;
`endif

    assign bus.mem_valid = mem_valid_reg;
    assign bus.mem_wr    = mem_wr_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.done0     = done_reg[0];
    assign bus.done1     = done_reg[1];
    assign bus.err0      = err_reg[0];
    assign bus.err1      = err_reg[1];
    assign bus.rdata0    = g_port[0].rdata_reg;
    assign bus.rdata1    = g_port[1].rdata_reg;
    assign busy          = (state_reg != IDLE);
    assign owner         = owner_reg;

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed bench for mem_arbiter_2port (TIMEOUT=8): read, write, stale ready,
// contention, timeout and reset during WAIT.
`timescale 1ns/1ps
module tb_mem_arbiter_2port;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic owner;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [7:0]  tmo_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done0  = 0;
    int n_done1  = 0;
    int n_both   = 0;

    mem_arbiter_2port_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter_2port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .owner   (owner)
`ifdef MEM_ARB_STATS_EN
        ,
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .tmo_cnt (tmo_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done0) n_done0 <= n_done0 + 1;
        if (bus.done1) n_done1 <= n_done1 + 1;
        if (bus.done0 && bus.done1) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps negedge by negedge after a grant until the port's done; raises
    // mem_ready at negedge ready_at, reports the done cycle and whether the
    // memory request stayed stable before done. Drops req in the done cycle.
    task automatic txn(input bit port, input int ready_at, output int done_at, output bit held);
        logic [31:0] a0;
        logic [31:0] d0;
        logic        w0;
        a0 = '0;
        d0 = '0;
        w0 = 1'b0;
        done_at = -1;
        held    = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a0 = bus.mem_addr;
                d0 = bus.mem_wdata;
                w0 = bus.mem_wr;
            end
            if (port ? bus.done1 : bus.done0) begin
                done_at = c;
                break;
            end
            if (!bus.mem_valid || bus.mem_addr !== a0 || bus.mem_wdata !== d0 || bus.mem_wr !== w0)
                held = 1'b0;
            if (c == ready_at) bus.mem_ready = 1'b1;
        end
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        bit h;
        int saved;
        logic [16:0] obs0;
        logic [16:0] obs1;

        bus.req0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_busy",      32'(busy),          0);
        check("rst_owner",     32'(owner),         1);
        check("rst_mem_valid", 32'(bus.mem_valid), 0);
        check("rst_mem_wr",    32'(bus.mem_wr),    0);
        check("rst_mem_addr",  bus.mem_addr,       0);
        check("rst_done_err",  32'({bus.done0, bus.done1, bus.err0, bus.err1}), 0);
        check("rst_rdata0",    bus.rdata0,         0);
        check("rst_rdata1",    bus.rdata1,         0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read, mem_ready sampled 5 edges after the grant
        bus.mem_rdata = 32'hDEADBEEF;
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'h10; bus.wdata0 = 32'hFFFF0000;
        txn(0, 5, d, h);
        check("rd_done_cycle", d, 6);
        check("rd_held",       32'(h), 1);
        check("rd_err0",       32'(bus.err0), 0);
        check("rd_valid_resp", 32'(bus.mem_valid), 0);
        check("rd_owner",      32'(owner), 0);
        check("rd_mem_addr",   bus.mem_addr, 32'h10);
        check("rd_mem_wr",     32'(bus.mem_wr), 0);
        check("rd_busy_resp",  32'(busy), 1);
        @(negedge clk); #2;
        check("rd_done_pulse", 32'(bus.done0), 0);
        check("rd_rdata0",     bus.rdata0, 32'hDEADBEEF);
        check("rd_rdata1",     bus.rdata1, 0);
        check("rd_n_done0",    n_done0, 1);
        check("rd_idle",       32'(busy), 0);

        // Write on port 1; rdata registers must not move
        bus.mem_rdata = 32'hCAFEF00D;
        bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 32'h24; bus.wdata1 = 32'h1234;
        txn(1, 3, d, h);
        check("wr_done_cycle", d, 4);
        check("wr_held",       32'(h), 1);
        check("wr_mem_wr",     32'(bus.mem_wr), 1);
        check("wr_mem_wdata",  bus.mem_wdata, 32'h1234);
        check("wr_mem_addr",   bus.mem_addr, 32'h24);
        check("wr_owner",      32'(owner), 1);
        check("wr_err1",       32'(bus.err1), 0);
        @(negedge clk); #2;
        check("wr_done_pulse", 32'(bus.done1), 0);
        check("wr_rdata1",     bus.rdata1, 0);
        check("wr_rdata0",     bus.rdata0, 32'hDEADBEEF);
        check("wr_n_done1",    n_done1, 1);

        // Stale ready: mem_ready already high, completion still 3 cycles
        bus.mem_ready = 1; bus.mem_rdata = 32'h55AA55AA;
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'h30;
        txn(0, 0, d, h);
        check("stale_done_cycle", d, 3);
        check("stale_held",       32'(h), 1);
        check("stale_owner",      32'(owner), 0);
        @(negedge clk); #2;
        check("stale_rdata0",     bus.rdata0, 32'h55AA55AA);

        // Contention from reset with mem_ready fixed high
        rst_n = 0;
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'h100;
        bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 32'h200;
        bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
        @(negedge clk);
        rst_n = 1;
        obs0 = '0;
        obs1 = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            obs0[c] = bus.done0;
            obs1[c] = bus.done1;
            if (c == 1) check("cont_owner_c1", 32'(owner), 0);
            if (c == 5) check("cont_addr_c5",  bus.mem_addr, 32'h200);
        end
        bus.req0 = 0; bus.req1 = 0; bus.mem_ready = 0;
        #2;
        check("cont_done0_cycles", 32'(obs0), 32'h00808);
        check("cont_done1_cycles", 32'(obs1), 32'h08080);
        check("cont_no_double",    n_both, 0);
        check("cont_rdata0",       bus.rdata0, 32'h11112222);
        check("cont_rdata1",       bus.rdata1, 32'h11112222);
`ifdef MEM_ARB_STATS_EN
        check("cont_cnt0", 32'(cnt0), 2);
        check("cont_cnt1", 32'(cnt1), 2);
`endif
        @(negedge clk);

        // Timeout: mem_ready never arrives
        bus.mem_rdata = 32'h99999999;
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'h40;
        txn(0, 0, d, h);
        check("tmo_done_cycle", d, TMO + 2);
        check("tmo_held",       32'(h), 1);
        check("tmo_err0",       32'(bus.err0), 1);
        check("tmo_valid_resp", 32'(bus.mem_valid), 0);
`ifdef MEM_ARB_STATS_EN
        check("tmo_cnt",        32'(tmo_cnt), 1);
        check("tmo_cnt0",       32'(cnt0), 2);
`endif
        @(negedge clk); #2;
        check("tmo_err_pulse",  32'(bus.err0), 0);
        check("tmo_rdata0",     bus.rdata0, 32'h11112222);

        // Reset asserted while in WAIT
        bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 32'h50; bus.wdata1 = 32'h77;
        repeat (3) @(negedge clk);
        check("rw_busy_wait",  32'(busy), 1);
        check("rw_valid_wait", 32'(bus.mem_valid), 1);
        #2;
        saved = n_done1;
        rst_n = 0;
        #1;
        check("rw_valid_async", 32'(bus.mem_valid), 0);
        check("rw_busy_async",  32'(busy), 0);
        check("rw_owner_async", 32'(owner), 1);
        @(negedge clk);
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'h60;
        rst_n = 1;
        txn(0, 2, d, h);
        bus.req1 = 0;
        check("rw_port0_first", d, 3);
        check("rw_owner",       32'(owner), 0);
        check("rw_mem_addr",    bus.mem_addr, 32'h60);
        repeat (3) @(negedge clk);
        #2;
        check("rw_no_done1",    n_done1, saved);
        check("rw_idle_after",  32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2port.md
Name: mem_arbiter_2port

Overview:
- Two-requester arbiter and sequencer in front of the shared cache/RAM memory port.
- Lets an instruction-side requester (port 0) and a data-side requester (port 1) share one memory handshake.
- Fair round-robin grant, one outstanding transaction at a time.
- Holds the downstream request stable until the memory signals completion; a watchdog timeout prevents a lock-up.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory side
- DATA_W, 32, data width for both requesters and the memory side
- TIMEOUT, 64, maximum cycles spent in WAIT before the transaction is aborted; legal range 2..255

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request, held until done0
- wr0  in  1  port 0 write(1)/read(0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- done0  out  1  port 0 one-cycle completion pulse
- err0  out  1  port 0 timeout flag, valid with done0
- rdata0  out  DATA_W  port 0 read data, held until next port 0 read completion
- req1 / wr1 / addr1 / wdata1 / done1 / err1 / rdata1  same as port 0, for port 1
- mem_valid  out  1  memory request active
- mem_wr  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory response/completion level
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state except IDLE
- owner  out  1  index of the current or last granted port

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - mem_valid, mem_wr, done0/1, err0/1, busy = 0.
  - mem_addr, mem_wdata, rdata0/1 = 0.
  - owner = 1, so port 0 wins the first tie.
  - Timeout counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high at the edge, grant it.
  - If both are high, grant the port != owner.
  - On grant, latch wr/addr/wdata into mem_* registers, set mem_valid=1, set owner=winner, go to ISSUE.
- ISSUE:
  - One cycle; mem_valid=1; mem_ready is ignored, because the memory response is registered and stale.
  - Go to WAIT and clear the counter.
- WAIT:
  - mem_valid=1 and all mem_* outputs stable.
  - If mem_ready is high at the edge: go to RESP and drop mem_valid. For a read, copy mem_rdata into the winner's rdata register.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT-1 without mem_ready: go to RESP with err for the winner set and that port's rdata unchanged.
- RESP:
  - done and err are registered outputs, driven high for exactly the one cycle the FSM is in RESP, then cleared.
  - mem_valid=0 throughout RESP.
  - Next state is IDLE unconditionally.
- Latency:
  - req sampled at edge k; mem_valid high after k.
  - mem_ready is sampled from edge k+2 onward.
  - The earliest done is the cycle after edge k+2 (3 cycles).
  - A timeout yields done after TIMEOUT+2 cycles.
- Requester rules:
  - A requester must keep req and its inputs stable until done.
  - It must drop req in the done cycle or be served again.
  - A req dropped mid-transaction does not cancel it; done/err still pulse.
  - Input changes after the grant are ignored.
- Fairness: back-to-back requests from both ports strictly alternate; a single active port is served every 4 cycles minimum.
- Reset mid-transaction: everything returns to reset values immediately; no done pulse; mem_valid drops asynchronously.
- Write completion leaves both rdata registers unchanged.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds outputs cnt0, cnt1 (16 bits): completed non-error transactions per port.
  - Adds output tmo_cnt (8 bits): timeouts on either port.
  - All counters saturate at max and reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read: req0=1, wr0=0, addr0=0x10; mem_ready rises 5 cycles after mem_valid with mem_rdata=0xDEADBEEF -> mem_addr=0x10, mem_wr=0; done0 pulses once; rdata0=0xDEADBEEF; err0=0; owner=0.
- Write: req1=1, wr1=1, addr1=0x24, wdata1=0x1234 -> mem_wr=1, mem_wdata=0x1234 stable until mem_ready; done1 pulses; rdata1 unchanged.
- Contention: req0 and req1 high continuously from reset, mem_ready fixed at 1 -> grants 0,1,0,1; each done pulse 4 cycles apart; never two done pulses in one cycle.
- Timeout: TIMEOUT=8, req0 read, mem_ready held 0 -> done0=1 and err0=1 exactly 10 cycles after grant; mem_valid low in the RESP cycle; rdata0 unchanged; tmo_cnt=1 when MEM_ARB_STATS_EN is defined.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> mem_valid=0 and busy=0 immediately; no done pulse; the next request after release is granted to port 0.
- Stale ready: mem_ready already high when the grant occurs -> still one ISSUE cycle; completion is not earlier than 3 cycles after the req edge.
